// File: rtl/reaction_pkg.sv
// Shared types and helpers for the multi-player reaction timer.
package reaction_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARM,
    ST_GO,
    ST_RESULT
  } state_t;

  // Galois feedback mask for taps 16,14,13,11
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int ms_div(input int clk_hz);
    return clk_hz / 1000;
  endfunction

endpackage

// File: rtl/reaction_timer_core_btn_sync_edge.sv
// Two-flop synchroniser with rising-edge pulse for an asynchronous button.
module btn_sync_edge (
  input  logic clk,
  input  logic ck_rst,
  input  logic i_async,
  output logic o_rise
);

  logic r_meta, r_sync, r_prev;

  // Reset to "pressed" so a button held through reset must release before it can trigger
  always_ff @(posedge clk) begin
    if (ck_rst) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
      r_prev <= 1'b1;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_rise = r_sync & ~r_prev;

endmodule

// File: rtl/reaction_timer_core.sv
// N-player reaction timer: random pre-delay, stimulus LED, per-player ms timestamps,
// false-start detection, winner selection and session-best tracking.
module reaction_timer_core
  import reaction_pkg::*;
#(
  parameter int          CLK_HZ       = 100_000_000,
  parameter int          N_PLAYERS    = 2,
  parameter int          TIME_W       = 14,
  parameter int          TIMEOUT_MS   = 9999,
  parameter int          MIN_DELAY_MS = 1000,
  parameter int          DELAY_W      = 11,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1,
  localparam int         WIN_W        = clog2_min1(N_PLAYERS)
) (
  input  logic                          clk,
  input  logic                          ck_rst,
  input  logic                          start_i,
  input  logic [N_PLAYERS-1:0]          btn_i,
  output logic                          stim_led_o,
  output logic                          busy_o,
  output logic                          done_o,
  output logic [N_PLAYERS-1:0]          false_start_o,
  output logic [N_PLAYERS-1:0]          time_valid_o,
  output logic [N_PLAYERS*TIME_W-1:0]   time_ms_o,
  output logic [WIN_W-1:0]              winner_o,
  output logic                          winner_valid_o,
  output logic                          timeout_o,
  output logic [TIME_W-1:0]             best_ms_o
);

  localparam int MS_DIV  = ms_div(CLK_HZ);
  localparam int PRE_W   = clog2_min1(MS_DIV);
  localparam int MAX_DLY = MIN_DELAY_MS + (2 ** DELAY_W) - 1;
  localparam int CNT_MAX = (MAX_DLY > TIMEOUT_MS) ? MAX_DLY : TIMEOUT_MS;
  localparam int CNT_W   = clog2_min1(CNT_MAX + 1);

  logic                              w_start_rise;
  logic [N_PLAYERS-1:0]              w_btn_rise;

  btn_sync_edge u_start_sync (
    .clk     (clk),
    .ck_rst  (ck_rst),
    .i_async (start_i),
    .o_rise  (w_start_rise)
  );

  for (genvar gp = 0; gp < N_PLAYERS; gp++) begin : g_btn
    btn_sync_edge u_btn_sync (
      .clk     (clk),
      .ck_rst  (ck_rst),
      .i_async (btn_i[gp]),
      .o_rise  (w_btn_rise[gp])
    );
  end

  state_t                            r_state, w_state_nxt;
  logic [15:0]                       r_lfsr;
  logic [PRE_W-1:0]                  r_pre;
  logic [CNT_W-1:0]                  r_ms, r_delay, w_delay, w_ms_lim;
  logic [N_PLAYERS-1:0]              r_fs, w_fs_nxt;
  logic [N_PLAYERS-1:0]              r_valid, w_valid_nxt;
  logic [N_PLAYERS-1:0][TIME_W-1:0]  r_time, w_time_nxt;
  logic                              r_timeout, w_timeout_nxt;
  logic [WIN_W-1:0]                  r_winner, w_win;
  logic                              r_wvalid, w_win_any;
  logic [TIME_W-1:0]                 w_win_time, r_best;
  logic                              r_done;
  logic                              w_clear, w_zero_cnt, w_enter_result;

  // Free-running LFSR supplies the random part of the pre-stimulus delay
  always_ff @(posedge clk) begin
    if (ck_rst) r_lfsr <= LFSR_SEED;
    else        r_lfsr <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? LFSR_TAPS : 16'h0000);
  end

  if (DELAY_W == 0) begin : g_fixed_delay
    assign w_delay = CNT_W'(MIN_DELAY_MS);
  end else begin : g_rand_delay
    assign w_delay = CNT_W'(MIN_DELAY_MS) + CNT_W'(r_lfsr[DELAY_W-1:0]);
  end

  always_ff @(posedge clk) begin
    if (ck_rst) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_fs_nxt      = r_fs;
    w_valid_nxt   = r_valid;
    w_time_nxt    = r_time;
    w_timeout_nxt = r_timeout;
    w_clear       = 1'b0;
    w_zero_cnt    = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_start_rise) begin
          w_state_nxt = ST_ARM;
          w_clear     = 1'b1;
        end
      end
      ST_ARM: begin
        w_fs_nxt = r_fs | w_btn_rise;
        if (&w_fs_nxt) begin
          w_state_nxt = ST_RESULT;
        end else if (r_ms >= r_delay) begin
          w_state_nxt = ST_GO;
          w_zero_cnt  = 1'b1;
        end
      end
      ST_GO: begin
        for (int p = 0; p < N_PLAYERS; p++) begin
          if (w_btn_rise[p] && !r_fs[p] && !r_valid[p]) begin
            w_valid_nxt[p] = 1'b1;
            w_time_nxt[p]  = TIME_W'(r_ms);
          end
        end
        if (&(w_valid_nxt | r_fs)) w_state_nxt = ST_RESULT;
        if (r_ms >= CNT_W'(TIMEOUT_MS)) begin
          w_state_nxt   = ST_RESULT;
          w_timeout_nxt = 1'b1;
        end
      end
      ST_RESULT: begin
        if (w_start_rise) begin
          w_state_nxt = ST_ARM;
          w_clear     = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (w_clear) begin
      w_fs_nxt      = '0;
      w_valid_nxt   = '0;
      w_time_nxt    = '0;
      w_timeout_nxt = 1'b0;
    end
  end

  // Scan the next-cycle times so a press latched on the final cycle still competes
  always_comb begin
    w_win      = '0;
    w_win_any  = 1'b0;
    w_win_time = '1;
    for (int p = 0; p < N_PLAYERS; p++) begin
      if (w_valid_nxt[p] && (!w_win_any || (w_time_nxt[p] < w_win_time))) begin
        w_win      = WIN_W'(p);
        w_win_any  = 1'b1;
        w_win_time = w_time_nxt[p];
      end
    end
  end

  assign w_enter_result = (w_state_nxt == ST_RESULT) && (r_state != ST_RESULT);
  assign w_ms_lim       = (r_state == ST_GO) ? CNT_W'(TIMEOUT_MS) : r_delay;

  always_ff @(posedge clk) begin
    if (ck_rst) begin
      r_pre     <= '0;
      r_ms      <= '0;
      r_delay   <= '0;
      r_fs      <= '0;
      r_valid   <= '0;
      r_time    <= '0;
      r_timeout <= 1'b0;
      r_winner  <= '0;
      r_wvalid  <= 1'b0;
      r_done    <= 1'b0;
      r_best    <= '1;
    end else begin
      r_fs      <= w_fs_nxt;
      r_valid   <= w_valid_nxt;
      r_time    <= w_time_nxt;
      r_timeout <= w_timeout_nxt;
      r_done    <= w_enter_result;
      if (w_clear) begin
        r_delay  <= w_delay;
        r_winner <= '0;
        r_wvalid <= 1'b0;
      end
      if (w_enter_result) begin
        r_winner <= w_win;
        r_wvalid <= w_win_any;
        if (w_win_any && (w_win_time < r_best)) r_best <= w_win_time;
      end
      if (w_clear || w_zero_cnt) begin
        r_pre <= '0;
        r_ms  <= '0;
      end else if (r_state == ST_ARM || r_state == ST_GO) begin
        if (r_pre == PRE_W'(MS_DIV - 1)) begin
          r_pre <= '0;
          if (r_ms < w_ms_lim) r_ms <= r_ms + 1'b1;
        end else begin
          r_pre <= r_pre + 1'b1;
        end
      end
    end
  end

  assign stim_led_o     = (r_state == ST_GO);
  assign busy_o         = (r_state == ST_ARM) || (r_state == ST_GO);
  assign done_o         = r_done;
  assign false_start_o  = r_fs;
  assign time_valid_o   = r_valid;
  assign time_ms_o      = r_time;
  assign winner_o       = r_winner;
  assign winner_valid_o = r_wvalid;
  assign timeout_o      = r_timeout;
  assign best_ms_o      = r_best;

endmodule

// File: tb/tb_reaction_timer_core.sv
// Directed bench for reaction_timer_core: 10 clk per ms, 2 players, fixed 5 ms pre-delay.
module tb_reaction_timer_core;

  logic        clk = 1'b0;
  logic        ck_rst = 1'b1;
  logic        start_i = 1'b0;
  logic [1:0]  btn_i = 2'b00;
  logic        stim_led_o, busy_o, done_o, winner_valid_o, timeout_o;
  logic [1:0]  false_start_o, time_valid_o;
  logic [27:0] time_ms_o;
  logic [0:0]  winner_o;
  logic [13:0] best_ms_o;

  int n_cmp = 0;
  int n_bad = 0;

  reaction_timer_core #(
    .CLK_HZ       (10_000),
    .N_PLAYERS    (2),
    .TIME_W       (14),
    .TIMEOUT_MS   (100),
    .MIN_DELAY_MS (5),
    .DELAY_W      (0),
    .LFSR_SEED    (16'hACE1)
  ) dut (
    .clk            (clk),
    .ck_rst         (ck_rst),
    .start_i        (start_i),
    .btn_i          (btn_i),
    .stim_led_o     (stim_led_o),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .false_start_o  (false_start_o),
    .time_valid_o   (time_valid_o),
    .time_ms_o      (time_ms_o),
    .winner_o       (winner_o),
    .winner_valid_o (winner_valid_o),
    .timeout_o      (timeout_o),
    .best_ms_o      (best_ms_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         rst;
    logic [1:0] fs;
    int         t0, t1;
    bit         mid;
    logic [1:0] e_fs, e_val;
    int         e_t0, e_t1, e_win;
    bit         e_wv, e_to, e_led;
    int         e_best;
  } vec_t;

  vec_t vecs[8];
  vec_t held;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    ck_rst = 1'b1;
    repeat (2) tick();
    ck_rst = 1'b0;
    repeat (4) tick();
  endtask

  task automatic start_round(input string tag);
    bit seen;
    seen = 1'b0;
    start_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (busy_o) begin
        seen = 1'b1;
        break;
      end
    end
    start_i = 1'b0;
    chk({tag, "_busy_seen"}, seen, 1);
  endtask

  // Returns with the bench #1 after the GO-entry edge when the LED is seen
  task automatic wait_led(output bit got_done, output bit led);
    got_done = 1'b0;
    led      = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (done_o) begin
        got_done = 1'b1;
        break;
      end
      if (stim_led_o) begin
        led = 1'b1;
        break;
      end
    end
  endtask

  task automatic run_row(input vec_t v, input string tag);
    bit got, led;
    if (v.rst) do_reset();
    start_round(tag);
    btn_i = btn_i | v.fs;
    wait_led(got, led);
    if (led) begin
      // k counts edges since GO entry; a pad raised at k is latched as ms (k+2)/10
      for (int k = 0; k < 1200; k++) begin
        if (v.t0 >= 0 && k == v.t0 * 10) btn_i[0] = 1'b1;
        if (v.t1 >= 0 && k == v.t1 * 10) btn_i[1] = 1'b1;
        if (v.mid && k == 100) start_i = 1'b1;
        if (v.mid && k == 104) start_i = 1'b0;
        tick();
        if (done_o) begin
          got = 1'b1;
          break;
        end
      end
    end
    chk({tag, "_done_seen"}, got, 1);
    chk({tag, "_led_seen"}, led, v.e_led);
    tick();
    chk({tag, "_done_pulse"}, done_o, 0);
    chk({tag, "_led_off"}, stim_led_o, 0);
    chk({tag, "_busy_off"}, busy_o, 0);
    chk({tag, "_fs"}, false_start_o, v.e_fs);
    chk({tag, "_valid"}, time_valid_o, v.e_val);
    chk({tag, "_time0"}, time_ms_o[13:0], v.e_t0);
    chk({tag, "_time1"}, time_ms_o[27:14], v.e_t1);
    chk({tag, "_winner"}, winner_o, v.e_win);
    chk({tag, "_wvalid"}, winner_valid_o, v.e_wv);
    chk({tag, "_timeout"}, timeout_o, v.e_to);
    chk({tag, "_best"}, best_ms_o, v.e_best);
    btn_i = 2'b00;
    repeat (5) tick();
  endtask

  initial begin
    bit got, led;

    //          rst fs     t0  t1 mid  e_fs   e_val  t0  t1 win wv to led best
    vecs[0] = '{0, 2'b00, 37, 52, 0, 2'b00, 2'b11, 37, 52, 0, 1, 0, 1, 37};
    vecs[1] = '{0, 2'b10, 20, -1, 0, 2'b10, 2'b01, 20,  0, 0, 1, 0, 1, 20};
    vecs[2] = '{0, 2'b11, -1, -1, 0, 2'b11, 2'b00,  0,  0, 0, 0, 0, 0, 20};
    vecs[3] = '{0, 2'b00, -1, -1, 0, 2'b00, 2'b00,  0,  0, 0, 0, 1, 1, 20};
    vecs[4] = '{0, 2'b00, 15, 15, 0, 2'b00, 2'b11, 15, 15, 0, 1, 0, 1, 15};
    vecs[5] = '{1, 2'b00, 37, 50, 0, 2'b00, 2'b11, 37, 50, 0, 1, 0, 1, 37};
    vecs[6] = '{0, 2'b00, 48, 60, 1, 2'b00, 2'b11, 48, 60, 0, 1, 0, 1, 37};
    vecs[7] = '{0, 2'b00, 30, 12, 0, 2'b00, 2'b11, 30, 12, 1, 1, 0, 1, 12};

    ck_rst = 1'b1;
    repeat (2) tick();
    chk("rst_led", stim_led_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_fs", false_start_o, 0);
    chk("rst_valid", time_valid_o, 0);
    chk("rst_time", time_ms_o, 0);
    chk("rst_winner", winner_o, 0);
    chk("rst_wvalid", winner_valid_o, 0);
    chk("rst_timeout", timeout_o, 0);
    chk("rst_best", best_ms_o, 16383);
    ck_rst = 1'b0;
    repeat (4) tick();

    for (int i = 0; i < 8; i++) run_row(vecs[i], $sformatf("vec%0d", i));

    // Reset mid-GO with both buttons already rising, then held through the next round
    start_round("mg");
    wait_led(got, led);
    chk("mg_led_on", led, 1);
    repeat (30) tick();
    btn_i = 2'b11;
    tick();
    ck_rst = 1'b1;
    tick();
    chk("mg_rst_led", stim_led_o, 0);
    chk("mg_rst_busy", busy_o, 0);
    chk("mg_rst_best", best_ms_o, 16383);
    chk("mg_rst_valid", time_valid_o, 0);
    ck_rst = 1'b0;
    repeat (5) tick();
    held = '{0, 2'b00, -1, -1, 0, 2'b00, 2'b00, 0, 0, 0, 0, 1, 1, 16383};
    run_row(held, "held");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
